// File: rtl/enc_top.sv
// enc_top: dual-channel incremental-encoder edge counter with arm/index gating.
// Optional `ENC_INPUT_SYNC_EN selects a two-flop input synchronizer (one stage otherwise).
`timescale 1ns/1ps
`default_nettype none

module enc_cnt #(
  parameter int CNT_W = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             arm_i,
  input  logic             a_rise_i,
  input  logic             z_rise_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             overflow_o,
  output logic             ready_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_Z = 2'd1, ACTIVE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               rdy_q, rdy_d;
  logic               w_stm_active;

  assign w_stm_active = (state_q == ACTIVE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      rdy_q   <= rdy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    rdy_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // Count and flag survive disarm for readout; they are cleared only on re-arm.
        if (arm_i) begin
          state_d = WAIT_Z;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      WAIT_Z: begin
        if (!arm_i)        state_d = IDLE;
        else if (z_rise_i) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (!arm_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (w_stm_active && arm_i && a_rise_i) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      rdy_d = 1'b1;
      if (&cnt_q) ovf_d = 1'b1;
    end
  end

  assign cnt_o      = cnt_q;
  assign overflow_o = ovf_q;
  assign ready_o    = rdy_q;

endmodule

module enc_top #(
  parameter int CNT_W = 64
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             I_ARM,
  input  logic             I_SEL,
  input  logic             I_A0,
  input  logic             I_A1,
  input  logic             I_Z0,
  input  logic             I_Z1,
  output logic             O_A0,
  output logic             O_A1,
  output logic             O_Z0,
  output logic             O_Z1,
  output logic             O_SEL,
  output logic [CNT_W-1:0] O_CNT_A0,
  output logic [CNT_W-1:0] O_CNT_A1,
  output logic             O_OVERFLOW_0,
  output logic             O_OVERFLOW_1,
  output logic             O_READY_0,
  output logic             O_READY_1
);

`ifdef ENC_INPUT_SYNC_EN
  localparam int SYNC_DEPTH = 2;
`else
  localparam int SYNC_DEPTH = 1;
`endif

  // Bit order: {Z1, Z0, A1, A0, SEL, ARM}
  logic [5:0] sync_q [SYNC_DEPTH];
  logic [3:0] prev_q;
  logic [5:0] w_in;
  logic [5:0] w_sync;
  logic [3:0] w_rise;

  assign w_in   = {I_Z1, I_Z0, I_A1, I_A0, I_SEL, I_ARM};
  assign w_sync = sync_q[SYNC_DEPTH-1];
  assign w_rise = w_sync[5:2] & ~prev_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < SYNC_DEPTH; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= w_in;
      for (int i = 1; i < SYNC_DEPTH; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= w_sync[5:2];
    end
  end

  assign O_SEL = w_sync[1];
  assign O_A0  = w_sync[2];
  assign O_A1  = w_sync[3];
  assign O_Z0  = w_sync[4];
  assign O_Z1  = w_sync[5];

  enc_cnt #(.CNT_W(CNT_W)) ENC_CNT0 (
    .clk_i      (CLK),
    .rst_i      (RST),
    .arm_i      (w_sync[0]),
    .a_rise_i   (w_rise[0]),
    .z_rise_i   (w_rise[2]),
    .cnt_o      (O_CNT_A0),
    .overflow_o (O_OVERFLOW_0),
    .ready_o    (O_READY_0)
  );

  enc_cnt #(.CNT_W(CNT_W)) ENC_CNT1 (
    .clk_i      (CLK),
    .rst_i      (RST),
    .arm_i      (w_sync[0]),
    .a_rise_i   (w_rise[1]),
    .z_rise_i   (w_rise[3]),
    .cnt_o      (O_CNT_A1),
    .overflow_o (O_OVERFLOW_1),
    .ready_o    (O_READY_1)
  );

endmodule

`default_nettype wire

// File: tb/tb_enc_top.sv
// tb_enc_top: directed bench for enc_top; a 64-bit and a 4-bit instance share stimulus.
`timescale 1ns/1ps
`default_nettype none

module tb_enc_top;

`ifdef ENC_INPUT_SYNC_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic arm = 1'b0, sel = 1'b0, a0 = 1'b0, a1 = 1'b0, z0 = 1'b0, z1 = 1'b0;

  logic        O_A0, O_A1, O_Z0, O_Z1, O_SEL;
  logic [63:0] O_CNT_A0, O_CNT_A1;
  logic        O_OVERFLOW_0, O_OVERFLOW_1, O_READY_0, O_READY_1;

  logic        m_a0, m_a1, m_z0, m_z1, m_sel;
  logic [3:0]  m_cnt0, m_cnt1;
  logic        m_ovf0, m_ovf1, m_ready0, m_ready1;

  int n_pass = 0, n_total = 0, rdy0_seen = 0, rdy1_seen = 0;
  logic [63:0] q0[$], q1[$];
  logic [63:0] exp0 = 64'd0, exp1 = 64'd0, e0, e1;
  logic        act0 = 1'b0, act1 = 1'b0;

  always #5 clk = ~clk;

  enc_top dut (
    .CLK(clk), .RST(rst), .I_ARM(arm), .I_SEL(sel),
    .I_A0(a0), .I_A1(a1), .I_Z0(z0), .I_Z1(z1),
    .O_A0(O_A0), .O_A1(O_A1), .O_Z0(O_Z0), .O_Z1(O_Z1), .O_SEL(O_SEL),
    .O_CNT_A0(O_CNT_A0), .O_CNT_A1(O_CNT_A1),
    .O_OVERFLOW_0(O_OVERFLOW_0), .O_OVERFLOW_1(O_OVERFLOW_1),
    .O_READY_0(O_READY_0), .O_READY_1(O_READY_1)
  );

  enc_top #(.CNT_W(4)) dut4 (
    .CLK(clk), .RST(rst), .I_ARM(arm), .I_SEL(sel),
    .I_A0(a0), .I_A1(a1), .I_Z0(z0), .I_Z1(z1),
    .O_A0(m_a0), .O_A1(m_a1), .O_Z0(m_z0), .O_Z1(m_z1), .O_SEL(m_sel),
    .O_CNT_A0(m_cnt0), .O_CNT_A1(m_cnt1),
    .O_OVERFLOW_0(m_ovf0), .O_OVERFLOW_1(m_ovf1),
    .O_READY_0(m_ready0), .O_READY_1(m_ready1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_a0();
    a0 = 1'b1;
    if (act0) begin exp0++; q0.push_back(exp0); end
    cyc(3);
    a0 = 1'b0;
    cyc(3);
  endtask

  task automatic set_a1(input logic v);
    if (v && !a1 && act1) begin exp1++; q1.push_back(exp1); end
    a1 = v;
  endtask

  task automatic pulse_z0();
    z0 = 1'b1; cyc(2); z0 = 1'b0; cyc(S + 3);
    act0 = 1'b1;
  endtask

  task automatic pulse_z1();
    z1 = 1'b1; cyc(2); z1 = 1'b0; cyc(S + 3);
    act1 = 1'b1;
  endtask

  // Scoreboard: every strobe must match the next expected count on both widths.
  always @(negedge clk) begin
    if (!rst) begin
      if (O_READY_0) begin
        rdy0_seen++;
        if (q0.size() == 0) chk("ready0_spurious", 64'(O_READY_0), 64'd0);
        else begin
          e0 = q0.pop_front();
          chk("cnt0", O_CNT_A0, e0);
          chk("cnt0_w4", 64'(m_cnt0), 64'(e0[3:0]));
          chk("ready0_w4", 64'(m_ready0), 64'd1);
        end
      end else if (m_ready0) chk("ready0_w4_spurious", 64'(m_ready0), 64'd0);
      if (O_READY_1) begin
        rdy1_seen++;
        if (q1.size() == 0) chk("ready1_spurious", 64'(O_READY_1), 64'd0);
        else begin
          e1 = q1.pop_front();
          chk("cnt1", O_CNT_A1, e1);
          chk("cnt1_w4", 64'(m_cnt1), 64'(e1[3:0]));
          chk("ready1_w4", 64'(m_ready1), 64'd1);
        end
      end else if (m_ready1) chk("ready1_w4_spurious", 64'(m_ready1), 64'd0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    cyc(3);
    chk("rst_cnt0", O_CNT_A0, 64'd0);
    chk("rst_cnt1", O_CNT_A1, 64'd0);
    chk("rst_flags", 64'({O_A0, O_A1, O_Z0, O_Z1, O_SEL, O_OVERFLOW_0, O_OVERFLOW_1,
                          O_READY_0, O_READY_1, m_ovf0, m_ovf1, m_ready0, m_ready1}), 64'd0);
    rst = 1'b0;
    cyc(2);

    // Disarmed: A0 toggles, forwarded copy lags by S cycles, nothing counts
    for (int i = 0; i < 10; i++) begin
      a0 = ~a0;
      cyc(S - 1);
      chk("fwd_a0_early", 64'(O_A0), 64'(!a0));
      cyc(1);
      chk("fwd_a0", 64'(O_A0), 64'(a0));
      cyc(2);
    end
    sel = 1'b1; a1 = 1'b1; z0 = 1'b1; z1 = 1'b1;
    cyc(S - 1);
    chk("fwd_other_early", 64'({O_SEL, O_A1, O_Z0, O_Z1}), 64'h0);
    cyc(1);
    chk("fwd_other", 64'({O_SEL, O_A1, O_Z0, O_Z1}), 64'hF);
    sel = 1'b0; a1 = 1'b0; z0 = 1'b0; z1 = 1'b0;
    cyc(S + 2);
    chk("idle_cnt0", O_CNT_A0, 64'd0);
    chk("idle_ready0", 64'(rdy0_seen), 64'd0);

    // Arm; A0 edges before Z0 are ignored, 5 after Z0 count
    arm = 1'b1;
    rdy0_seen = 0;
    cyc(S + 2);
    repeat (3) pulse_a0();
    chk("prez_cnt0", O_CNT_A0, 64'd0);
    pulse_z0();
    repeat (5) pulse_a0();
    cyc(S + 2);
    chk("count5_cnt0", O_CNT_A0, 64'd5);
    chk("count5_strobes", 64'(rdy0_seen), 64'd5);
    chk("count5_ovf0", 64'(O_OVERFLOW_0), 64'd0);
    chk("count5_q0", 64'(q0.size()), 64'd0);
    chk("count5_cnt1", O_CNT_A1, 64'd0);

    // Disarm holds the count; re-arm clears it at cycle S+1
    repeat (2) pulse_a0();
    cyc(S + 2);
    chk("count7_cnt0", O_CNT_A0, 64'd7);
    arm = 1'b0; act0 = 1'b0;
    cyc(S + 3);
    repeat (2) pulse_a0();
    chk("disarm_hold", O_CNT_A0, 64'd7);
    arm = 1'b1; exp0 = 64'd0;
    cyc(S);
    chk("rearm_before", O_CNT_A0, 64'd7);
    cyc(1);
    chk("rearm_clear", O_CNT_A0, 64'd0);
    repeat (2) pulse_a0();
    cyc(S + 2);
    chk("rearm_noz", O_CNT_A0, 64'd0);

    // 17 edges wrap the 4-bit instance once
    pulse_z0();
    rdy0_seen = 0;
    repeat (17) pulse_a0();
    cyc(S + 2);
    chk("wrap_cnt0_64", O_CNT_A0, 64'd17);
    chk("wrap_ovf0_64", 64'(O_OVERFLOW_0), 64'd0);
    chk("wrap_cnt0_w4", 64'(m_cnt0), 64'd1);
    chk("wrap_ovf0_w4", 64'(m_ovf0), 64'd1);
    chk("wrap_strobes", 64'(rdy0_seen), 64'd17);
    arm = 1'b0; act0 = 1'b0;
    cyc(S + 3);
    chk("wrap_disarm_ovf", 64'(m_ovf0), 64'd1);
    chk("wrap_disarm_cnt", 64'(m_cnt0), 64'd1);
    arm = 1'b1; exp0 = 64'd0;
    cyc(S + 2);
    chk("wrap_rearm_ovf", 64'(m_ovf0), 64'd0);
    chk("wrap_rearm_cnt", 64'(m_cnt0), 64'd0);

    // Channel 1 counts with periodic Z1; channel 0 stays waiting for Z0
    pulse_z1();
    rdy1_seen = 0;
    for (int i = 0; i < 10; i++) begin
      set_a1(1'b1);
      cyc(125);
      a0 = 1'b1;
      cyc(125);
      set_a1(1'b0);
      cyc(60);
      if (i % 3 == 2) begin z1 = 1'b1; cyc(2); z1 = 1'b0; end
      else cyc(2);
      cyc(63);
      a0 = 1'b0;
      cyc(125);
    end
    chk("indep_cnt1", O_CNT_A1, 64'd10);
    chk("indep_ovf1", 64'(O_OVERFLOW_1), 64'd0);
    chk("indep_strobes1", 64'(rdy1_seen), 64'd10);
    chk("indep_q1", 64'(q1.size()), 64'd0);
    chk("indep_cnt0", O_CNT_A0, 64'd0);

    // Asynchronous reset mid-count
    pulse_z0();
    repeat (3) pulse_a0();
    sel = 1'b1;
    cyc(S + 2);
    chk("pre_rst_cnt0", O_CNT_A0, 64'd3);
    rst = 1'b1;
    #2;
    chk("async_rst_cnt0", O_CNT_A0, 64'd0);
    chk("async_rst_cnt1", O_CNT_A1, 64'd0);
    chk("async_rst_flags", 64'({O_A0, O_A1, O_Z0, O_Z1, O_SEL, O_OVERFLOW_0, O_OVERFLOW_1,
                                O_READY_0, O_READY_1, m_ovf0, m_ovf1, m_ready0, m_ready1}), 64'd0);
    chk("async_rst_cnt_w4", 64'({m_cnt0, m_cnt1}), 64'd0);
    act0 = 1'b0; act1 = 1'b0; exp0 = 64'd0; exp1 = 64'd0;
    q0.delete(); q1.delete();
    sel = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(2);
    repeat (3) pulse_a0();
    cyc(S + 2);
    chk("post_rst_noz", O_CNT_A0, 64'd0);
    pulse_z0();
    repeat (2) pulse_a0();
    cyc(S + 2);
    chk("post_rst_cnt0", O_CNT_A0, 64'd2);
    chk("post_rst_q0", 64'(q0.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
